day_12_line_parser: RTL
=======================

# day_12_line_parser

Upstream front end for the `day_12` packing solver. It consumes the raw puzzle text as an AXI-Stream of ASCII bytes and recognises region lines of the form `WxH: c0 c1 c2 c3 c4 c5`. For each region line it emits the solver's input word sequence: one dimensions word, then exactly six count words. Shape-definition lines (`N:`, `#`/`.` rows) and blank lines are discarded.

## Interface
- `DIGIT_SAT`, default 255: saturation value for every parsed number; must be ≤ 255.
- `N_SHAPES`, default 6: number of count words emitted per region.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `s_tvalid`  in  1  ASCII byte valid.
- `s_tready`  out  1  byte accepted when `s_tvalid && s_tready`.
- `s_tdata`  in  8  ASCII byte.
- `m_tvalid`  out  1  output word valid; connects to `day_12.s_tvalid`.
- `m_tready`  in  1  downstream ready.
- `m_tdata`  out  32  `{16'b0, W[7:0], H[7:0]}` for dimensions, `{24'b0, cnt[7:0]}` for counts.
- `region_cnt`  out  16  number of dimensions words emitted, wrapping.
- `err`  out  1  sticky malformed-line flag.

## Operation
- Number accumulator `acc`: `acc = min(acc*10 + digit, DIGIT_SAT)`, computed 9+ bits wide before the saturation compare. A digit is `8'h30`–`8'h39`.
- `\r` (`8'h0D`) is ignored in every state. `\n` is `8'h0A`.
- States:
  - S_LINE (reset state):
    - digit → load `acc`, go to S_W.
    - `\n` → stay.
    - any other byte → S_SKIP.
  - S_W:
    - digit → accumulate.
    - `x` → latch `W = acc`, clear `acc`, go to S_H.
    - `:` → S_SKIP. This is a shape header, not an error.
    - `\n` → S_LINE.
    - any other byte → S_SKIP.
  - S_H:
    - digit → accumulate and set `have_digit`.
    - `:` with `have_digit` → emit the dimensions word, increment `region_cnt`, set `idx = 0`, go to S_CNT.
    - `:` without `have_digit`, or any other byte → set `err`, go to S_SKIP, or to S_LINE if the byte was `\n`.
  - S_CNT:
    - digit → accumulate and set `have_digit`.
    - space with `have_digit` → emit the count word if `idx < N_SHAPES`, otherwise set `err` and drop it. Then increment `idx` (saturating at `N_SHAPES`) and clear `acc`/`have_digit`.
    - space without `have_digit` → ignored.
    - `\n` → emit the pending count under the same rule, then go to S_PAD if `idx < N_SHAPES`, else S_LINE.
    - any other byte → set `err`, byte ignored.
  - S_PAD:
    - `s_tready = 0`.
    - Emits zero count words until `idx == N_SHAPES`, setting `err` once on entry, then goes to S_LINE.
  - S_SKIP: discard bytes until `\n`, then go to S_LINE.
- Every region line therefore yields exactly 1 + `N_SHAPES` output words.

## Timing
- Reset values: `m_tvalid=0`, `m_tdata=0`, `s_tready=0` during reset, `region_cnt=0`, `err=0`, state S_LINE, `acc=0`, `idx=0`.
- Output is a single registered word. `m_tvalid`/`m_tdata` hold stable until `m_tready`.
- `s_tready = !m_tvalid && state != S_PAD && !rst`. No combinational path from `m_tready` to `s_tready`.
- Latency: the delimiter byte accepted in cycle N gives `m_tvalid=1` in cycle N+1.
- With `m_tready=1`: one word every 2 cycles at most; input stalls 1 cycle per emitted word.
- S_PAD emits one zero word per accepted output handshake.
- Backpressure: while `m_tvalid && !m_tready`, no input is accepted and parser state is frozen.
- `rst` mid-line or mid-word: the pending word is dropped (`m_tvalid=0` next cycle) and everything returns to reset values.
- `region_cnt` wraps 16'hFFFF → 0.

## Test plan
- `"4x4: 1 0 0 0 0 0\n"` with `m_tready=1` → words `0x00000404, 1, 0, 0, 0, 0, 0`; `region_cnt=1`; `err=0`.
- Shape block `"0:\n###\n##.\n##.\n\n"` followed by `"12x5: 2 1 0 0 0 0\r\n"` → only `0x00000C05, 2, 1, 0, 0, 0, 0`; `err=0`.
- `"16x16: 300 0 0 0 0 0\n"` → `0x00001010`, then 255 (saturated), then five zeros.
- `"5x5: 3 4\n"` → `0x00000505, 3, 4, 0, 0, 0, 0`; `err=1`. Also `"5x5: 1 1 1 1 1 1 9\n"` → the seventh count is dropped and `err=1`.
- Random `m_tready` throttling (~50%) over 20 region lines → the word sequence is identical to the unthrottled run; `m_tdata` is stable while `m_tvalid && !m_tready`.
- Assert `rst` for 1 cycle after `"8x8: 1 "` → the next line `"6x6: 0 1 0 0 0 0\n"` produces exactly 7 correct words; `region_cnt=1`.

Source files
------------

// File: rtl/day_12_line_parser.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : day_12_line_parser
// Brief    : ASCII AXI-Stream front end that turns "WxH: c0 .. c5" region
//            lines into one dimensions word followed by N_SHAPES count words.
// Revision : 1.0  initial release
// ============================================================================
module day_12_line_parser #(
    parameter int DIGIT_SAT = 255,
    parameter int N_SHAPES  = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [7:0]  s_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [31:0] m_tdata,
    output logic [15:0] region_cnt,
    output logic        err
);

    localparam int                   c_IDX_W = $clog2(N_SHAPES + 1);
    localparam logic [c_IDX_W-1:0]   c_N     = c_IDX_W'(N_SHAPES);
    localparam logic [11:0]          c_SAT   = 12'(DIGIT_SAT);

    typedef enum logic [2:0] {
        S_LINE = 3'd0,
        S_W    = 3'd1,
        S_H    = 3'd2,
        S_CNT  = 3'd3,
        S_PAD  = 3'd4,
        S_SKIP = 3'd5
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [7:0]           r_acc, w_acc_nxt;
    logic [7:0]           r_w, w_w_nxt;
    logic                 r_have_digit, w_have_digit_nxt;
    logic [c_IDX_W-1:0]   r_idx, w_idx_nxt;
    logic                 r_m_tvalid;
    logic [31:0]          r_m_tdata;
    logic [15:0]          r_region_cnt;
    logic                 r_err;

    logic                 w_emit;
    logic [31:0]          w_emit_data;
    logic                 w_err_set;
    logic                 w_region_inc;
    logic                 w_accept;
    logic                 w_is_digit, w_is_cr, w_is_nl, w_is_x, w_is_colon, w_is_space;
    logic [c_IDX_W-1:0]   w_idx_inc;
    logic [c_IDX_W-1:0]   w_idx_after;

    // Full-width product so the saturation compare sees the true value.
    function automatic logic [7:0] f_accum(input logic [7:0] base, input logic [3:0] d);
        logic [11:0] p;
        p = ({4'b0, base} * 12'd10) + {8'b0, d};
        return (p > c_SAT) ? c_SAT[7:0] : p[7:0];
    endfunction

    assign s_tready   = !r_m_tvalid && (r_state != S_PAD) && !rst;
    assign m_tvalid   = r_m_tvalid;
    assign m_tdata    = r_m_tdata;
    assign region_cnt = r_region_cnt;
    assign err        = r_err;

    assign w_accept   = s_tvalid && s_tready;
    assign w_is_digit = (s_tdata >= 8'h30) && (s_tdata <= 8'h39);
    assign w_is_cr    = (s_tdata == 8'h0D);
    assign w_is_nl    = (s_tdata == 8'h0A);
    assign w_is_x     = (s_tdata == 8'h78);
    assign w_is_colon = (s_tdata == 8'h3A);
    assign w_is_space = (s_tdata == 8'h20);
    assign w_idx_inc  = (r_idx == c_N) ? r_idx : r_idx + 1'b1;
    assign w_idx_after = r_have_digit ? w_idx_inc : r_idx;

    always_comb begin
        w_state_nxt      = r_state;
        w_acc_nxt        = r_acc;
        w_w_nxt          = r_w;
        w_have_digit_nxt = r_have_digit;
        w_idx_nxt        = r_idx;
        w_emit           = 1'b0;
        w_emit_data      = 32'd0;
        w_err_set        = 1'b0;
        w_region_inc     = 1'b0;

        if (r_state == S_PAD) begin
            // Padding waits for each zero word to drain before issuing the next.
            if (!r_m_tvalid) begin
                if (r_idx < c_N) begin
                    w_emit    = 1'b1;
                    w_idx_nxt = w_idx_inc;
                    if (w_idx_inc == c_N) w_state_nxt = S_LINE;
                end else begin
                    w_state_nxt = S_LINE;
                end
            end
        end else if (w_accept && !w_is_cr) begin
            case (r_state)
                S_LINE: begin
                    if (w_is_digit) begin
                        w_acc_nxt        = f_accum(8'd0, s_tdata[3:0]);
                        w_have_digit_nxt = 1'b0;
                        w_state_nxt      = S_W;
                    end else if (!w_is_nl) begin
                        w_state_nxt = S_SKIP;
                    end
                end
                S_W: begin
                    if (w_is_digit) begin
                        w_acc_nxt = f_accum(r_acc, s_tdata[3:0]);
                    end else if (w_is_x) begin
                        w_w_nxt          = r_acc;
                        w_acc_nxt        = 8'd0;
                        w_have_digit_nxt = 1'b0;
                        w_state_nxt      = S_H;
                    end else if (w_is_nl) begin
                        w_state_nxt = S_LINE;
                    end else begin
                        w_state_nxt = S_SKIP;
                    end
                end
                S_H: begin
                    if (w_is_digit) begin
                        w_acc_nxt        = f_accum(r_acc, s_tdata[3:0]);
                        w_have_digit_nxt = 1'b1;
                    end else if (w_is_colon && r_have_digit) begin
                        w_emit           = 1'b1;
                        w_emit_data      = {16'b0, r_w, r_acc};
                        w_region_inc     = 1'b1;
                        w_idx_nxt        = '0;
                        w_acc_nxt        = 8'd0;
                        w_have_digit_nxt = 1'b0;
                        w_state_nxt      = S_CNT;
                    end else begin
                        w_err_set   = 1'b1;
                        w_state_nxt = w_is_nl ? S_LINE : S_SKIP;
                    end
                end
                S_CNT: begin
                    if (w_is_digit) begin
                        w_acc_nxt        = f_accum(r_acc, s_tdata[3:0]);
                        w_have_digit_nxt = 1'b1;
                    end else if (w_is_space || w_is_nl) begin
                        if (r_have_digit) begin
                            if (r_idx < c_N) begin
                                w_emit      = 1'b1;
                                w_emit_data = {24'b0, r_acc};
                            end else begin
                                w_err_set = 1'b1;
                            end
                            w_idx_nxt        = w_idx_inc;
                            w_acc_nxt        = 8'd0;
                            w_have_digit_nxt = 1'b0;
                        end
                        if (w_is_nl) begin
                            if (w_idx_after < c_N) begin
                                w_err_set   = 1'b1;
                                w_state_nxt = S_PAD;
                            end else begin
                                w_state_nxt = S_LINE;
                            end
                        end
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
                S_SKIP: begin
                    if (w_is_nl) w_state_nxt = S_LINE;
                end
                default: w_state_nxt = S_LINE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_LINE;
            r_acc        <= 8'd0;
            r_w          <= 8'd0;
            r_have_digit <= 1'b0;
            r_idx        <= '0;
            r_m_tvalid   <= 1'b0;
            r_m_tdata    <= 32'd0;
            r_region_cnt <= 16'd0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_acc        <= w_acc_nxt;
            r_w          <= w_w_nxt;
            r_have_digit <= w_have_digit_nxt;
            r_idx        <= w_idx_nxt;
            r_err        <= r_err | w_err_set;
            r_region_cnt <= r_region_cnt + {15'd0, w_region_inc};
            if (w_emit) begin
                r_m_tvalid <= 1'b1;
                r_m_tdata  <= w_emit_data;
            end else if (r_m_tvalid && m_tready) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
